// File: rtl/conv_feeder_pkg.sv
// Shared constants, types and helpers for the conv engine stream feeder.
package conv_feeder_pkg;

  localparam int NUM_ROWS = 7;
  localparam int WIN_COLS = 3;
  localparam int PIX_W    = 8;
  localparam int WIN_W    = WIN_COLS * PIX_W;
  localparam int PARAM_W  = 26;

  localparam logic [1:0] TAG_WEIGHT = 2'd0;
  localparam logic [1:0] TAG_BIAS   = 2'd1;

  // Header is three weight rows followed by one bias word.
  localparam logic [1:0] HDR_LAST = 2'd3;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Tag and trim a header word: weight rows keep 24 bits, bias keeps 8.
  function automatic logic [PARAM_W-1:0] fmt_param(input logic is_bias,
                                                   input logic [23:0] d);
    if (is_bias) return {TAG_BIAS, 16'd0, d[7:0]};
    else         return {TAG_WEIGHT, d};
  endfunction

endpackage

// File: rtl/row_window.sv
// One row of the sliding window: WIN_COLS-deep pixel shift register.
// Newest pixel lands in the low byte; next_o exposes the post-shift value.
module row_window #(
  parameter int PIX_W    = 8,
  parameter int WIN_COLS = 3
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      shift_i,
  input  logic                      clear_i,
  input  logic [PIX_W-1:0]          pix_i,
  output logic [PIX_W*WIN_COLS-1:0] win_o,
  output logic [PIX_W*WIN_COLS-1:0] next_o
);

  logic [PIX_W*WIN_COLS-1:0] win_q;

  assign next_o = {win_q[PIX_W*(WIN_COLS-1)-1:0], pix_i};
  assign win_o  = win_q;

  // Shift on each accepted column; clear wins so a strip's end leaves it empty.
  always_ff @(posedge clk_i) begin
    if (!rstn_i)      win_q <= '0;
    else if (clear_i) win_q <= '0;
    else if (shift_i) win_q <= next_o;
  end

endmodule

// File: rtl/conv_feeder.sv
// Feeds the 3x3 conv engine from the MM2S stream: parses the per-strip
// header into tagged params, then slides 7-row windows over pixel columns.
module conv_feeder
  import conv_feeder_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [PARAM_W-1:0] o_param,
  output logic               o_param_valid,
  output logic [WIN_W-1:0]   pe_1,
  output logic [WIN_W-1:0]   pe_2,
  output logic [WIN_W-1:0]   pe_3,
  output logic [WIN_W-1:0]   pe_4,
  output logic [WIN_W-1:0]   pe_5,
  output logic [WIN_W-1:0]   pe_6,
  output logic [WIN_W-1:0]   pe_7,
  output logic               pe_valid,
  output logic               o_strip_done,
  output logic [CNT_W-1:0]   o_cols,
  output logic               o_err
);

  state_e                            state_q;
  logic [1:0]                        hdr_cnt_q;
  logic [CNT_W-1:0]                  col_cnt_q, col_cnt_d;
  logic                              s_ready_q;
  logic [PARAM_W-1:0]                param_q;
  logic                              param_vld_q;
  logic [NUM_ROWS-1:0][WIN_W-1:0]    pe_q;
  logic                              pe_vld_q;
  logic                              done_q;
  logic [CNT_W-1:0]                  cols_q;
  logic                              err_q;

  logic                              acc, col_acc, strip_end;
  logic [NUM_ROWS-1:0][WIN_W-1:0]    win, win_next;

  // Top byte of each stream word carries no pixels.
  logic unused_hi;
  assign unused_hi = ^s_data[DATA_W-1:NUM_ROWS*PIX_W];

  // conv cannot stall, so ready only drops for the first cycle out of reset.
  assign acc       = s_valid & s_ready_q;
  assign col_acc   = acc & (state_q != HDR);
  assign strip_end = col_acc & s_last;

  // Column counter saturates instead of wrapping on oversize strips.
  assign col_cnt_d = (&col_cnt_q) ? col_cnt_q : col_cnt_q + 1'b1;

  genvar k;
  generate
    for (k = 0; k < NUM_ROWS; k++) begin : g_row
      row_window #(.PIX_W(PIX_W), .WIN_COLS(WIN_COLS)) u_row (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .shift_i (col_acc),
        .clear_i (strip_end),
        .pix_i   (s_data[k*PIX_W +: PIX_W]),
        .win_o   (win[k]),
        .next_o  (win_next[k])
      );
    end
  endgenerate

  // Strip FSM: header parsing, window fill, run; all outputs registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= HDR;
      hdr_cnt_q   <= '0;
      col_cnt_q   <= '0;
      s_ready_q   <= 1'b0;
      param_q     <= '0;
      param_vld_q <= 1'b0;
      pe_q        <= '0;
      pe_vld_q    <= 1'b0;
      done_q      <= 1'b0;
      cols_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      s_ready_q   <= 1'b1;
      param_vld_q <= 1'b0;
      pe_vld_q    <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        HDR: begin
          if (acc) begin
            if (s_last) begin
              // Truncated header: flag it and restart header parsing.
              err_q     <= 1'b1;
              hdr_cnt_q <= '0;
            end else begin
              param_q     <= fmt_param(hdr_cnt_q == HDR_LAST, s_data[23:0]);
              param_vld_q <= 1'b1;
              if (hdr_cnt_q == HDR_LAST) begin
                hdr_cnt_q <= '0;
                state_q   <= FILL;
              end else begin
                hdr_cnt_q <= hdr_cnt_q + 2'd1;
              end
            end
          end
        end
        FILL, RUN: begin
          if (acc) begin
            if (state_q == RUN) begin
              pe_q     <= win_next;
              pe_vld_q <= 1'b1;
            end
            if (s_last) begin
              done_q    <= 1'b1;
              cols_q    <= col_cnt_d;
              col_cnt_q <= '0;
              state_q   <= HDR;
            end else begin
              col_cnt_q <= col_cnt_d;
              if (state_q == FILL && col_cnt_q == CNT_W'(1)) state_q <= RUN;
            end
          end
        end
        default: state_q <= HDR;
      endcase
    end
  end

  assign s_ready       = s_ready_q;
  assign o_param       = param_q;
  assign o_param_valid = param_vld_q;
  assign pe_valid      = pe_vld_q;
  assign o_strip_done  = done_q;
  assign o_cols        = cols_q;
  assign o_err         = err_q;
  assign pe_1          = pe_q[0];
  assign pe_2          = pe_q[1];
  assign pe_3          = pe_q[2];
  assign pe_4          = pe_q[3];
  assign pe_5          = pe_q[4];
  assign pe_6          = pe_q[5];
  assign pe_7          = pe_q[6];

endmodule

// File: tb/tb_conv_feeder.sv
// Directed bench for conv_feeder: header parsing, window sliding, strip end,
// header errors, short strips and mid-strip reset.
module tb_conv_feeder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [25:0] o_param;
  logic        o_param_valid;
  logic [23:0] pe_1, pe_2, pe_3, pe_4, pe_5, pe_6, pe_7;
  logic        pe_valid;
  logic        o_strip_done;
  logic [15:0] o_cols;
  logic        o_err;

  logic [23:0] pe [7];
  assign pe[0] = pe_1; assign pe[1] = pe_2; assign pe[2] = pe_3;
  assign pe[3] = pe_4; assign pe[4] = pe_5; assign pe[5] = pe_6;
  assign pe[6] = pe_7;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_feeder #(.DATA_W(64), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .o_param(o_param),
    .o_param_valid(o_param_valid), .pe_1(pe_1), .pe_2(pe_2), .pe_3(pe_3),
    .pe_4(pe_4), .pe_5(pe_5), .pe_6(pe_6), .pe_7(pe_7), .pe_valid(pe_valid),
    .o_strip_done(o_strip_done), .o_cols(o_cols), .o_err(o_err)
  );

  // Present one word for one cycle; returns 1 time unit after the accepting edge.
  task automatic put(input logic [63:0] d, input logic l);
    @(negedge clk);
    s_data = d; s_valid = 1'b1; s_last = l;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); @(posedge clk); #1; end
  endtask

  // Column c with every pixel equal to c.
  function automatic logic [63:0] col_u(input int c);
    logic [7:0] b;
    b = 8'(c);
    return {8'h00, {7{b}}};
  endfunction

  // Row-distinct pixel value for column c, row k (0-based); top byte is junk.
  function automatic logic [7:0] px(input int c, input int k);
    return 8'(c * 16 + k + 1);
  endfunction

  function automatic logic [63:0] col_d(input int c);
    logic [63:0] r;
    r = 64'hEE00_0000_0000_0000;
    for (int k = 0; k < 7; k++) r[8*k +: 8] = px(c, k);
    return r;
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %0h expected 0", s_ready); end
    checks++; if ({o_param, o_param_valid, pe_valid, o_strip_done, o_cols, o_err} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %0h/%0h/%0h/%0h/%0h/%0h expected 0",
                         o_param, o_param_valid, pe_valid, o_strip_done, o_cols, o_err); end
    for (int k = 0; k < 7; k++) begin
      checks++; if (pe[k] !== 24'h0) begin errors++; $display("FAIL reset_pe%0d: got %0h expected 0", k + 1, pe[k]); end
    end
    @(negedge clk); rstn = 1'b1; #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL release_s_ready_low: got %0h expected 0", s_ready); end
    @(posedge clk); #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready_high: got %0h expected 1", s_ready); end
  endtask

  // Header words with junk in bits the feeder must ignore.
  task automatic test_header();
    logic [63:0] w [4];
    logic [25:0] e [4];
    w = '{64'hAB00_0000_FF11_2233, 64'h0000_0000_0044_5566,
          64'hFFFF_FFFF_FF77_8899, 64'hFFFF_FFFF_FFFF_FF05};
    e = '{26'h0112233, 26'h0445566, 26'h0778899, 26'h1000005};
    for (int i = 0; i < 4; i++) begin
      put(w[i], 1'b0);
      checks++; if (o_param_valid !== 1'b1) begin errors++; $display("FAIL hdr%0d_valid: got %0h expected 1", i, o_param_valid); end
      checks++; if (o_param !== e[i]) begin errors++; $display("FAIL hdr%0d_param: got %0h expected %0h", i, o_param, e[i]); end
      checks++; if (pe_valid !== 1'b0) begin errors++; $display("FAIL hdr%0d_pe_valid: got %0h expected 0", i, pe_valid); end
    end
    idle(1);
    checks++; if (o_param_valid !== 1'b0) begin errors++; $display("FAIL hdr_valid_pulse: got %0h expected 0", o_param_valid); end
  endtask

  // Five uniform columns following a header: three windows, then strip end.
  task automatic test_columns();
    logic [23:0] ev;
    for (int c = 1; c <= 5; c++) begin
      put(col_u(c), c == 5);
      checks++; if (pe_valid !== (c >= 3)) begin errors++; $display("FAIL col%0d_pe_valid: got %0h expected %0h", c, pe_valid, c >= 3); end
      checks++; if (o_param_valid !== 1'b0) begin errors++; $display("FAIL col%0d_param_valid: got %0h expected 0", c, o_param_valid); end
      checks++; if (o_strip_done !== (c == 5)) begin errors++; $display("FAIL col%0d_done: got %0h expected %0h", c, o_strip_done, c == 5); end
      if (c >= 3) begin
        ev = {8'(c - 2), 8'(c - 1), 8'(c)};
        for (int k = 0; k < 7; k++) begin
          checks++; if (pe[k] !== ev) begin errors++; $display("FAIL col%0d_pe%0d: got %0h expected %0h", c, k + 1, pe[k], ev); end
        end
      end
    end
    checks++; if (o_cols !== 16'd5) begin errors++; $display("FAIL strip_cols: got %0d expected 5", o_cols); end
    idle(1);
    checks++; if ({pe_valid, o_strip_done} !== 2'b00) begin errors++; $display("FAIL strip_after: got %0h expected 0", {pe_valid, o_strip_done}); end
  endtask

  // Columns with 0..3 idle cycles between them; windows hold during gaps.
  task automatic test_gaps();
    logic [23:0] ev;
    test_header();
    for (int c = 1; c <= 6; c++) begin
      put(col_d(c), c == 6);
      checks++; if (pe_valid !== (c >= 3)) begin errors++; $display("FAIL gap_col%0d_pe_valid: got %0h expected %0h", c, pe_valid, c >= 3); end
      if (c >= 3) begin
        for (int k = 0; k < 7; k++) begin
          ev = {px(c - 2, k), px(c - 1, k), px(c, k)};
          checks++; if (pe[k] !== ev) begin errors++; $display("FAIL gap_col%0d_pe%0d: got %0h expected %0h", c, k + 1, pe[k], ev); end
        end
      end
      if (c < 6) begin
        for (int g = 0; g < (c - 1) % 4; g++) begin
          idle(1);
          checks++; if (pe_valid !== 1'b0) begin errors++; $display("FAIL gap%0d_%0d_pe_valid: got %0h expected 0", c, g, pe_valid); end
          if (c >= 3) begin
            ev = {px(c - 2, 6), px(c - 1, 6), px(c, 6)};
            checks++; if (pe_7 !== ev) begin errors++; $display("FAIL gap%0d_%0d_hold: got %0h expected %0h", c, g, pe_7, ev); end
          end
        end
      end
    end
    checks++; if (o_strip_done !== 1'b1) begin errors++; $display("FAIL gap_done: got %0h expected 1", o_strip_done); end
    checks++; if (o_cols !== 16'd6) begin errors++; $display("FAIL gap_cols: got %0d expected 6", o_cols); end
  endtask

  // s_last on the third header word: error, no param, recover on next header.
  task automatic test_hdr_err();
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_before: got %0h expected 0", o_err); end
    put(64'h0000_0000_00AA_0001, 1'b0);
    put(64'h0000_0000_00AA_0002, 1'b0);
    checks++; if (o_param !== 26'h0AA0002) begin errors++; $display("FAIL err_hdr1: got %0h expected aa0002", o_param); end
    put(64'h0000_0000_00AA_0003, 1'b1);
    checks++; if (o_param_valid !== 1'b0) begin errors++; $display("FAIL err_no_param: got %0h expected 0", o_param_valid); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_set: got %0h expected 1", o_err); end
    test_header();
    test_columns();
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0h expected 1", o_err); end
  endtask

  // Strips of 2 and 1 columns never produce a window.
  task automatic test_short_strip();
    test_header();
    put(col_u(7), 1'b0);
    checks++; if ({pe_valid, o_strip_done} !== 2'b00) begin errors++; $display("FAIL short2_c1: got %0h expected 0", {pe_valid, o_strip_done}); end
    put(col_u(8), 1'b1);
    checks++; if (pe_valid !== 1'b0) begin errors++; $display("FAIL short2_pe_valid: got %0h expected 0", pe_valid); end
    checks++; if (o_strip_done !== 1'b1) begin errors++; $display("FAIL short2_done: got %0h expected 1", o_strip_done); end
    checks++; if (o_cols !== 16'd2) begin errors++; $display("FAIL short2_cols: got %0d expected 2", o_cols); end
    test_header();
    put(col_u(9), 1'b1);
    checks++; if (pe_valid !== 1'b0) begin errors++; $display("FAIL short1_pe_valid: got %0h expected 0", pe_valid); end
    checks++; if (o_strip_done !== 1'b1) begin errors++; $display("FAIL short1_done: got %0h expected 1", o_strip_done); end
    checks++; if (o_cols !== 16'd1) begin errors++; $display("FAIL short1_cols: got %0d expected 1", o_cols); end
    test_header();
    test_columns();
  endtask

  // One-cycle reset in the middle of RUN discards everything.
  task automatic test_mid_reset();
    test_header();
    for (int c = 1; c <= 3; c++) put(col_u(c), 1'b0);
    checks++; if (pe_valid !== 1'b1) begin errors++; $display("FAIL mrst_run: got %0h expected 1", pe_valid); end
    @(negedge clk); rstn = 1'b0;
    @(posedge clk); #1;
    checks++; if ({s_ready, o_param, o_param_valid, pe_valid, o_strip_done, o_cols, o_err} !== '0) begin
      errors++; $display("FAIL mrst_outputs: got %0h/%0h/%0h/%0h/%0h/%0h/%0h expected 0",
                         s_ready, o_param, o_param_valid, pe_valid, o_strip_done, o_cols, o_err); end
    for (int k = 0; k < 7; k++) begin
      checks++; if (pe[k] !== 24'h0) begin errors++; $display("FAIL mrst_pe%0d: got %0h expected 0", k + 1, pe[k]); end
    end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    test_header();
    test_columns();
  endtask

  initial begin
    test_reset();
    test_header();
    test_columns();
    test_gaps();
    test_hdr_err();
    test_short_strip();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
